// File: rtl/scan_controller_if.sv
// rtl/scan_controller_if.sv - layout/change handshake between scan_controller and the MCU link
interface scan_controller_if;
  logic [63:0] layout;
  logic [63:0] change;
  logic        layout_valid;
  logic        layout_ready;

  modport master (
    output layout,
    output change,
    output layout_valid,
    input  layout_ready
  );

  modport slave (
    input  layout,
    input  change,
    input  layout_valid,
    output layout_ready
  );
endinterface

// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - 8x8 reed matrix row scanner with frame debounce and change reporting
module scan_controller #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       c,
  output logic [7:0]       r,
  scan_controller_if.master link
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE4     = 4'(STABLE_FRAMES);
  localparam logic [4:0] STABLE5     = 5'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_COMPARE,
    S_PRESENT
  } state_t;

  state_t      state, state_n;
  logic [2:0]  row;
  logic [7:0]  cnt;
  logic [7:0]  c_m, c_s;
  logic [63:0] frame, cand;
  logic [3:0]  m, m_next;
  logic [4:0]  m_sum;
  logic [63:0] layout_q, change_q;
  logic        valid_q;
  logic        row_done, accept;

  assign link.layout       = layout_q;
  assign link.change       = change_q;
  assign link.layout_valid = valid_q;

  always_comb begin
    state_n  = state;
    r        = 8'h00;
    row_done = (state == S_DRIVE) && (cnt == SETTLE_LAST);
    m_sum    = {1'b0, m} + 5'd1;
    if (frame == cand) begin
      m_next = (m_sum >= STABLE5) ? STABLE4 : m_sum[3:0];
    end else begin
      m_next = 4'd1;
    end
    // Only a debounced frame that differs from the published layout is offered.
    accept = (m_next == STABLE4) && (frame != layout_q);

    unique case (state)
      S_IDLE: begin
        if (enable) state_n = S_DRIVE;
      end
      S_DRIVE: begin
        r = 8'h01 << row;
        if (row_done && row == 3'd7) state_n = S_COMPARE;
      end
      S_COMPARE: begin
        if (accept)      state_n = S_PRESENT;
        else if (enable) state_n = S_DRIVE;
        else             state_n = S_IDLE;
      end
      S_PRESENT: begin
        if (valid_q && link.layout_ready) state_n = enable ? S_DRIVE : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_m      <= 8'h00;
      c_s      <= 8'h00;
      row      <= 3'd0;
      cnt      <= 8'd0;
      frame    <= 64'd0;
      cand     <= 64'd0;
      m        <= 4'd0;
      layout_q <= 64'd0;
      change_q <= 64'd0;
      valid_q  <= 1'b0;
    end else begin
      c_m <= c;
      c_s <= c_m;
      unique case (state)
        S_IDLE: begin
          row <= 3'd0;
          cnt <= 8'd0;
        end
        S_DRIVE: begin
          if (row_done) begin
            // Row k lands in the byte starting at bit 8*(7-k); ~row is 7-row.
            frame[{~row, 3'b000} +: 8] <= c_s;
            cnt <= 8'd0;
            row <= row + 3'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_COMPARE: begin
          cand <= frame;
          m    <= m_next;
          row  <= 3'd0;
          cnt  <= 8'd0;
          if (accept) begin
            layout_q <= frame;
            change_q <= frame ^ layout_q;
            valid_q  <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (valid_q && link.layout_ready) valid_q <= 1'b0;
        end
        default: begin
          row <= 3'd0;
          cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// tb/tb_scan_controller.sv - randomized frame-level check of scan_controller against a debounce model
module tb_scan_controller;
  localparam int SETTLE = 4;
  localparam int STABLE = 3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        enable_def;
  logic [7:0]  c;
  logic [7:0]  c_def;
  logic [7:0]  r;
  logic [7:0]  r_def;
  logic [63:0] board;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] hist[$];
  logic [63:0] m_layout;
  logic [63:0] m_change;

  scan_controller_if lk();
  scan_controller_if lk_def();

  scan_controller #(.SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .c(c), .r(r), .link(lk.master)
  );

  scan_controller u_def (
    .clk(clk), .reset(reset), .enable(enable_def), .c(c_def), .r(r_def), .link(lk_def.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor matrix: the driven row's byte of the board appears on the columns.
  always_comb begin
    c = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (r[k]) c = board[63 - 8*k -: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // A layout is published when the last STABLE frames agree and differ from the current layout.
  task automatic model_frame(input logic [63:0] f, output bit rep);
    bit same;
    hist.push_back(f);
    if (hist.size() > STABLE) void'(hist.pop_front());
    same = (hist.size() == STABLE);
    foreach (hist[i]) if (hist[i] != f) same = 0;
    rep = same && (f != m_layout);
    if (rep) begin
      m_change = f ^ m_layout;
      m_layout = f;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_layout = 64'd0;
    m_change = 64'd0;
  endtask

  // Entered on the first cycle of row 0; returns on the cycle after COMPARE.
  task automatic do_frame(output bit rep);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < SETTLE; j++) begin
        check("row_r", {56'd0, r}, 64'(8'h01 << k));
        @(negedge clk);
      end
    end
    check("cmp_r", {56'd0, r}, 64'd0);
    model_frame(board, rep);
    @(negedge clk);
    check("post_valid", {63'd0, lk.layout_valid}, {63'd0, rep});
    if (rep) begin
      check("post_layout", lk.layout, m_layout);
      check("post_change", lk.change, m_change);
      check("present_r", {56'd0, r}, 64'd0);
    end else begin
      check("next_r", {56'd0, r}, enable ? 64'd1 : 64'd0);
    end
  endtask

  task automatic transfer(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", {63'd0, lk.layout_valid}, 64'd1);
      check("bp_layout", lk.layout, m_layout);
      check("bp_change", lk.change, m_change);
      check("bp_r", {56'd0, r}, 64'd0);
      @(negedge clk);
    end
    lk.layout_ready = 1'b1;
    @(negedge clk);
    lk.layout_ready = 1'b0;
    check("xfer_valid", {63'd0, lk.layout_valid}, 64'd0);
    check("xfer_r", {56'd0, r}, enable ? 64'd1 : 64'd0);
  endtask

  task automatic wait_r(input logic [7:0] val, input string tag);
    for (int i = 0; i < 200 && r !== val; i++) @(negedge clk);
    check(tag, {56'd0, r}, {56'd0, val});
  endtask

  initial begin
    bit rep;
    bit got;
    logic [63:0] pool[4];

    reset = 1'b0;
    enable = 1'b0;
    enable_def = 1'b0;
    c_def = 8'hA5;
    lk.layout_ready = 1'b0;
    lk_def.layout_ready = 1'b1;
    board = 64'd0;
    model_reset();

    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_r", {56'd0, r}, 64'd0);
      check("idle_valid", {63'd0, lk.layout_valid}, 64'd0);
      check("idle_layout", lk.layout, 64'd0);
      check("idle_change", lk.change, 64'd0);
      check("def_r", {56'd0, r_def}, 64'd0);
      check("def_valid", {63'd0, lk_def.layout_valid}, 64'd0);
      check("def_layout", lk_def.layout, 64'd0);
      check("def_change", lk_def.change, 64'd0);
      c_def = 8'($urandom);
    end

    board = 64'hFF00_0000_0000_0000;
    enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) do_frame(rep);
    check("scan_valid", {63'd0, lk.layout_valid}, 64'd1);
    check("scan_layout", lk.layout, 64'hFF00_0000_0000_0000);
    check("scan_change", lk.change, 64'hFF00_0000_0000_0000);
    transfer(10);

    for (int f = 0; f < 20; f++) begin
      board = (f % 2 == 0) ? 64'hFF00_0001_0000_0000 : 64'hFF00_0000_0000_0000;
      do_frame(rep);
      check("bounce_valid", {63'd0, lk.layout_valid}, 64'd0);
    end

    board = 64'hFF00_0000_0000_1000;
    got = 0;
    for (int f = 0; f < STABLE + 1 && !got; f++) begin
      do_frame(rep);
      if (rep) begin
        got = 1;
        check("move_a_change", lk.change, 64'h0000_0000_0000_1000);
        transfer(0);
      end
    end
    check("move_a_seen", {63'd0, got}, 64'd1);

    board = 64'hFF00_0000_0010_0000;
    got = 0;
    for (int f = 0; f < STABLE + 1 && !got; f++) begin
      do_frame(rep);
      if (rep) begin
        got = 1;
        check("move_b_change", lk.change, 64'h0000_0000_0010_1000);
        transfer(1);
      end
    end
    check("move_b_seen", {63'd0, got}, 64'd1);
    for (int f = 0; f < 5; f++) begin
      do_frame(rep);
      check("static_valid", {63'd0, lk.layout_valid}, 64'd0);
    end

    foreach (pool[i]) pool[i] = {$urandom, $urandom};
    for (int it = 0; it < 20; it++) begin
      board = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) board = 64'd0;
      for (int h = $urandom_range(1, 4); h > 0; h--) begin
        do_frame(rep);
        if (rep) transfer($urandom_range(0, 3));
      end
    end

    wait_r(8'h10, "wait_row4");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("rst_r", {56'd0, r}, 64'd0);
    check("rst_valid", {63'd0, lk.layout_valid}, 64'd0);
    check("rst_layout", lk.layout, 64'd0);
    check("rst_change", lk.change, 64'd0);

    wait_r(8'h04, "wait_row2");
    enable = 1'b0;
    wait_r(8'h80, "finish_row7");
    wait_r(8'h00, "finish_cmp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stop_r", {56'd0, r}, 64'd0);
      check("stop_valid", {63'd0, lk.layout_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_controller.md
# scan_controller

Sequences the 8x8 reed-sensor matrix under the chessboard. It drives one-hot row strobes with a programmable settle time and samples the column inputs, then debounces complete board frames. It publishes only changed, stable layouts to the downstream MCU-link logic over a valid/ready handshake. It sits between the board I/O pins and the SPI/MCU interface.

## Interface
- SETTLE_CYCLES, 16: cycles each row is driven; legal range 3..255.
- STABLE_FRAMES, 4: consecutive identical frames required before a layout is accepted; legal range 1..15.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  run scanning
- c  in  8  raw column sense lines (asynchronous to clk)
- r  out  8  one-hot row drive; 0 when no row is driven
- layout  out  64  last accepted board; row k occupies bits [63-8k:56-8k], column j is bit j of that byte
- change  out  64  layout XOR previous layout, captured at acceptance
- layout_valid  out  1  layout/change offered
- layout_ready  in  1  downstream accepts

## Operation
- Input sync: c passes through a 2-flop synchronizer (c_s). All samples use c_s.
- States:
  - IDLE: r=0. If enable=1, go to DRIVE with row=0 and cnt=0.
  - DRIVE: r=1<<row and cnt increments each cycle.
    - When cnt==SETTLE_CYCLES-1: frame byte for row is written from c_s and cnt is cleared.
    - If row<7: row increments and state stays DRIVE.
    - If row==7: go to COMPARE.
  - COMPARE (1 cycle, r=0):
    - m' = (frame==cand) ? min(m+1, STABLE_FRAMES) : 1. Then cand<=frame and m<=m'.
    - If m'==STABLE_FRAMES and frame!=layout: layout<=frame, change<=frame^layout, layout_valid<=1, go to PRESENT.
    - Else go to DRIVE (row 0) if enable=1, otherwise IDLE.
  - PRESENT: r=0 and scanning is paused. Transfer occurs on a cycle with layout_valid=1 and layout_ready=1. On the next cycle layout_valid=0 and the state goes to DRIVE (row 0) if enable=1, otherwise IDLE.
- Once STABLE_FRAMES is reached, an unchanged board is never re-reported, however long it stays. Because layout resets to 0, an all-empty board is never reported after reset.
- enable is examined only in IDLE, in COMPARE, and on leaving PRESENT. Deasserting enable mid-frame lets the current frame complete.
- layout and change are held constant while layout_valid=1. They update only in COMPARE.
- Reset (reset=0 on a rising edge), including mid-frame or mid-PRESENT, forces the following values on the next cycle:
  - state IDLE, r=0, row=0, cnt=0
  - frame=0, cand=0, m=0
  - layout=0, change=0, layout_valid=0
  - both synchronizer stages cleared

## Timing
- Reset values of all outputs: r=0, layout=0, change=0, layout_valid=0.
- IDLE with enable=1 at edge t gives r=8'h01 from cycle t+1.
- Each row is driven for exactly SETTLE_CYCLES cycles. The sample is taken in the row's last driven cycle, so c must be stable at least 2 cycles before that cycle.
- Frame period is 8*SETTLE_CYCLES+1 cycles. r is 0 only in the COMPARE cycle.
- layout_valid rises in the cycle after COMPARE.
- A board change held static is reported within STABLE_FRAMES+1 frames.
- layout_ready has no combinational path to any output.
- Row transitions go directly from one one-hot value to the next, with no overlap or gap inside a frame.

## Test plan
- Reset and idle, default parameters:
  - Stimulus: hold reset=0 for 2 cycles, then set reset=1 with enable=0 for 50 cycles.
  - Required: r=0, layout=0, change=0, layout_valid=0 throughout.
- Scan sequence, SETTLE_CYCLES=4, STABLE_FRAMES=3:
  - Stimulus: enable=1; c=8'hFF while r=8'h01, else c=0.
  - Required: r cycles 01,02,04,…,80, each for 4 cycles, with a 33-cycle frame.
  - Required: after the 3rd COMPARE, layout_valid=1, layout=64'hFF00_0000_0000_0000, change=layout.
- Bounce rejection:
  - Stimulus: the row-3 byte alternates 8'h01 and 8'h00 every frame for 20 frames.
  - Required: layout_valid never asserts.
- Backpressure:
  - Stimulus: layout_ready=0 for 10 cycles after valid asserts.
  - Required: layout_valid, layout and change stay constant and r=0 during those cycles.
  - Stimulus: pulse layout_ready=1 for one cycle.
  - Required: layout_valid=0 and r=8'h01 on the next cycle.
- Move detection:
  - Stimulus: from an accepted layout, clear bit 12 and set bit 20.
  - Required: one transfer with change=64'h0000_0000_0010_1000.
  - Required: further identical frames produce no new layout_valid.
- Mid-operation control:
  - Stimulus: reset=0 while r=8'h10.
  - Required: on the next cycle all outputs are 0.
  - Stimulus: deassert enable while r=8'h04.
  - Required: the frame finishes through r=8'h80 and COMPARE, then r stays 0.
